// File: rtl/sdiv_select_seq_if.sv
// sdiv_select_seq_if -- operand/result bundle for sdiv_select_seq.
//
// Handshake: the master holds a, b, c, d and zero stable while it raises
// start for one cycle. The slave samples start only when busy is low; the
// operands are captured on that same edge. A start seen while busy is
// dropped, not queued. The slave then pulses valid for exactly one cycle,
// with z and dz already updated. busy stays high until the cycle after that
// pulse. There is no backpressure: the master must take z when valid is high,
// although z and dz also hold their values until the next result.
//
// Signals:
//   start      master -> slave  request pulse
//   a, c       master -> slave  signed dividends
//   b, d       master -> slave  signed divisors
//   zero       master -> slave  value that a%b is compared against
//   z          slave -> master  registered result
//   valid      slave -> master  one-cycle result strobe
//   busy       slave -> master  high in every state except IDLE
//   dz         slave -> master  a divisor used by the last operation was zero
//   dbg_state  slave -> master  FSM state encoding, for debug only
interface sdiv_select_seq_if #(
    parameter int DATAWIDTH = 64
);
    logic                        start;
    logic signed [DATAWIDTH-1:0] a;
    logic signed [DATAWIDTH-1:0] b;
    logic signed [DATAWIDTH-1:0] c;
    logic signed [DATAWIDTH-1:0] d;
    logic signed [DATAWIDTH-1:0] zero;
    logic signed [DATAWIDTH-1:0] z;
    logic                        valid;
    logic                        busy;
    logic                        dz;
    logic [2:0]                  dbg_state;

    modport master (
        output start, a, b, c, d, zero,
        input  z, valid, busy, dz, dbg_state
    );

    modport slave (
        input  start, a, b, c, d, zero,
        output z, valid, busy, dz, dbg_state
    );
endinterface

// File: rtl/sdiv_select_seq.sv
// sdiv_select_seq -- computes e=a/b and g=a%b. It returns z=c/d when g equals
// `zero`; otherwise it returns z=e. One shared restoring divider does the
// work. The divider produces one quotient bit per clock and works on operand
// magnitudes; the sign is fixed up afterwards. Quotients truncate toward zero
// and each remainder takes the sign of its dividend.
//
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-high reset
//   bus  sdiv_select_seq_if.slave: start/a/b/c/d/zero in,
//        z/valid/busy/dz/dbg_state out
module sdiv_select_seq #(
    parameter int DATAWIDTH = 64
) (
    input  logic             clk,
    input  logic             rst,
    sdiv_select_seq_if.slave bus
);
    localparam int W  = DATAWIDTH;
    localparam int CW = $clog2(W + 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_DIV_AB = 3'd1,
        S_CHECK  = 3'd2,
        S_DIV_CD = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t r_state;
    state_t w_next;

    logic signed [W-1:0] r_a, r_b, r_c, r_d, r_zero;
    logic signed [W-1:0] r_z;
    logic                r_dz;
    logic                r_sel;   // 0: divider holds a/b, 1: divider holds c/d
    logic [W-1:0]        r_quo;   // dividend magnitude shifting out, quotient in
    logic [W-1:0]        r_rem;   // partial remainder
    logic [W-1:0]        r_dvs;   // divisor magnitude
    logic [CW-1:0]       r_cnt;

    logic signed [W-1:0] w_dividend, w_divisor;
    logic [W:0]          w_shift, w_diff;
    logic [W-1:0]        w_quo_nx, w_rem_nx;
    logic signed [W-1:0] w_q, w_r;
    logic                w_last_ab, w_last_cd;

    // Two's-complement magnitude. The most-negative value maps to 2^(W-1),
    // which still fits in W unsigned bits.
    function automatic logic [W-1:0] mag(input logic signed [W-1:0] v);
        return v[W-1] ? (~v + 1'b1) : v;
    endfunction

    // One restoring step. The partial remainder is always below the divisor,
    // and the divisor is at most 2^(W-1). The shifted value therefore fits in
    // W+1 bits, and bit W of the difference acts as the borrow.
    always_comb begin
        w_dividend = r_sel ? r_c : r_a;
        w_divisor  = r_sel ? r_d : r_b;
        w_shift    = {r_rem, r_quo[W-1]};
        w_diff     = w_shift - {1'b0, r_dvs};
        if (!w_diff[W]) begin
            w_rem_nx = w_diff[W-1:0];
            w_quo_nx = {r_quo[W-2:0], 1'b1};
        end else begin
            w_rem_nx = w_shift[W-1:0];
            w_quo_nx = {r_quo[W-2:0], 1'b0};
        end
        // Sign fix-up. A zero divisor overrides the result: quotient 0 and
        // remainder equal to the dividend.
        if (w_divisor == '0) begin
            w_q = '0;
            w_r = w_dividend;
        end else begin
            w_q = (w_dividend[W-1] ^ w_divisor[W-1]) ? (~r_quo + 1'b1) : r_quo;
            w_r = w_dividend[W-1] ? (~r_rem + 1'b1) : r_rem;
        end
        w_last_ab = (r_cnt == CW'(W - 1));
        w_last_cd = (r_cnt == CW'(W));
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    // Next-state logic.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (bus.start) w_next = S_DIV_AB;
            S_DIV_AB: if (w_last_ab) w_next = S_CHECK;
            S_CHECK:  w_next = (w_r == r_zero) ? S_DIV_CD : S_DONE;
            // DIV_CD spends one extra cycle after its last step to load z.
            S_DIV_CD: if (w_last_cd) w_next = S_DONE;
            S_DONE:   w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    // Outputs. Every path into DONE loads z on the entering edge, so valid is
    // simply "in DONE".
    always_comb begin
        bus.busy      = (r_state != S_IDLE);
        bus.valid     = (r_state == S_DONE);
        bus.z         = r_z;
        bus.dz        = r_dz;
        bus.dbg_state = r_state;
    end

    // Datapath.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a    <= '0;
            r_b    <= '0;
            r_c    <= '0;
            r_d    <= '0;
            r_zero <= '0;
            r_z    <= '0;
            r_dz   <= 1'b0;
            r_sel  <= 1'b0;
            r_quo  <= '0;
            r_rem  <= '0;
            r_dvs  <= '0;
            r_cnt  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_a    <= bus.a;
                        r_b    <= bus.b;
                        r_c    <= bus.c;
                        r_d    <= bus.d;
                        r_zero <= bus.zero;
                        r_sel  <= 1'b0;
                        r_quo  <= mag(bus.a);
                        r_rem  <= '0;
                        r_dvs  <= mag(bus.b);
                        r_cnt  <= '0;
                    end
                end
                S_DIV_AB: begin
                    r_quo <= w_quo_nx;
                    r_rem <= w_rem_nx;
                    r_cnt <= w_last_ab ? '0 : r_cnt + 1'b1;
                end
                S_CHECK: begin
                    if (w_r == r_zero) begin
                        // Reload the shared divider with c/d.
                        r_sel <= 1'b1;
                        r_quo <= mag(r_c);
                        r_rem <= '0;
                        r_dvs <= mag(r_d);
                        r_cnt <= '0;
                    end else begin
                        r_z  <= w_q;
                        r_dz <= (r_b == '0);
                    end
                end
                S_DIV_CD: begin
                    if (!w_last_cd) begin
                        r_quo <= w_quo_nx;
                        r_rem <= w_rem_nx;
                        r_cnt <= r_cnt + 1'b1;
                    end else begin
                        r_z   <= w_q;
                        r_dz  <= (r_b == '0) || (r_d == '0);
                        r_cnt <= '0;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_sdiv_select_seq.sv
module tb_sdiv_select_seq;
    logic clk = 1'b0;
    logic rst8;
    logic rst64;
    int   n_tests = 0;
    int   n_fail  = 0;

    sdiv_select_seq_if #(.DATAWIDTH(8))  bus8 ();
    sdiv_select_seq_if #(.DATAWIDTH(64)) bus64 ();

    sdiv_select_seq #(.DATAWIDTH(8))  dut8  (.clk(clk), .rst(rst8),  .bus(bus8));
    sdiv_select_seq #(.DATAWIDTH(64)) dut64 (.clk(clk), .rst(rst64), .bus(bus64));

    // ---------------- clock / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1, "watchdog");
    end

    // ---------------- checker ----------------
    task automatic check_eq(input string tag, input longint got, input longint exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // Sign-extend the low w bits of v.
    function automatic longint wrapw(input longint v, input int w);
        return (v <<< (64 - w)) >>> (64 - w);
    endfunction

    task automatic ref_divmod(input int w, input longint x, input longint y,
                              output longint q, output longint r);
        if (y == 0) begin
            q = 0;
            r = x;
        end else if (y == -1) begin
            q = wrapw(-x, w);
            r = 0;
        end else begin
            q = x / y;
            r = x % y;
        end
    endtask

    task automatic ref_model(input int w, input longint a, b, c, d, zero,
                             output longint ez, output longint edz, output longint elat);
        longint e, g, f, fr;
        ref_divmod(w, a, b, e, g);
        if (g != zero) begin
            ez   = e;
            edz  = (b == 0) ? 1 : 0;
            elat = w + 1;
        end else begin
            ref_divmod(w, c, d, f, fr);
            ez   = f;
            edz  = (b == 0 || d == 0) ? 1 : 0;
            elat = 2 * w + 2;
        end
    endtask

    // ---------------- DUT access helpers ----------------
    function automatic logic get_valid(input bit wide);
        return wide ? bus64.valid : bus8.valid;
    endfunction

    function automatic logic get_busy(input bit wide);
        return wide ? bus64.busy : bus8.busy;
    endfunction

    function automatic logic get_dz(input bit wide);
        return wide ? bus64.dz : bus8.dz;
    endfunction

    function automatic longint get_z(input bit wide);
        longint v;
        if (wide) v = bus64.z;
        else      v = longint'(bus8.z);
        return v;
    endfunction

    task automatic drive(input bit wide, input logic s, input longint a, b, c, d, zero);
        if (wide) begin
            bus64.start = s;
            bus64.a = a; bus64.b = b; bus64.c = c; bus64.d = d; bus64.zero = zero;
        end else begin
            bus8.start = s;
            bus8.a = a[7:0]; bus8.b = b[7:0]; bus8.c = c[7:0]; bus8.d = d[7:0];
            bus8.zero = zero[7:0];
        end
    endtask

    function automatic longint rand_full();
        return longint'({$urandom, $urandom});
    endfunction

    function automatic longint rand_val(input int w);
        longint v;
        case ($urandom_range(0, 7))
            0:       v = 0;
            1:       v = -1;
            2:       v = -(longint'(1) <<< (w - 1));
            3:       v = longint'($urandom_range(0, 40)) - 20;
            4:       v = 1;
            default: v = rand_full();
        endcase
        return wrapw(v, w);
    endfunction

    task automatic wait_idle(input bit wide, input string tag);
        for (int i = 0; i < 400 && get_busy(wide); i++) @(negedge clk);
        check_eq({tag, "_idle"}, longint'(get_busy(wide)), 0);
    endtask

    // ---------------- one operation, checked against the model ----------------
    task automatic do_op(input bit wide, input longint a, b, c, d, zero, input string tag);
        int     w;
        longint ez, edz, elat;
        int     lat;
        bit     seen;
        w = wide ? 64 : 8;
        ref_model(w, a, b, c, d, zero, ez, edz, elat);
        wait_idle(wide, tag);
        @(negedge clk);
        drive(wide, 1'b1, a, b, c, d, zero);
        @(posedge clk);   // edge 0
        #1;
        // Scramble the inputs: the running operation must not see them.
        drive(wide, 1'b0, rand_full(), rand_full(), rand_full(), rand_full(), rand_full());
        seen = 1'b0;
        lat  = 0;
        for (int k = 1; k <= 3 * w + 10; k++) begin
            @(posedge clk);
            #1;
            if (k == 1) check_eq({tag, "_busy"}, longint'(get_busy(wide)), 1);
            if (get_valid(wide)) begin
                lat  = k;
                seen = 1'b1;
                break;
            end
        end
        check_eq({tag, "_valid_seen"}, longint'(seen), 1);
        if (seen) begin
            check_eq({tag, "_latency"}, longint'(lat), elat);
            check_eq({tag, "_z"}, get_z(wide), ez);
            check_eq({tag, "_dz"}, longint'(get_dz(wide)), edz);
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int     nvalid;
        int     vedge;
        longint a, b, c, d, zero, q, r;

        rst8  = 1'b1;
        rst64 = 1'b1;
        drive(1'b0, 1'b0, 0, 0, 0, 0, 0);
        drive(1'b1, 1'b0, 0, 0, 0, 0, 0);
        repeat (3) @(negedge clk);
        check_eq("rst_z8", get_z(1'b0), 0);
        check_eq("rst_valid8", longint'(bus8.valid), 0);
        check_eq("rst_busy8", longint'(bus8.busy), 0);
        check_eq("rst_dz8", longint'(bus8.dz), 0);
        check_eq("rst_z64", get_z(1'b1), 0);
        check_eq("rst_busy64", longint'(bus64.busy), 0);
        rst8  = 1'b0;
        rst64 = 1'b0;
        @(negedge clk);

        // Directed cases, 8-bit.
        do_op(1'b0, 21, 5, 3, 2, 0, "e_path");
        do_op(1'b0, 20, 5, -17, 4, 0, "f_path");
        do_op(1'b0, 7, 0, 1, 1, 0, "b_zero");
        do_op(1'b0, -128, -1, 3, 3, 5, "min_by_m1");
        do_op(1'b0, -17, 4, 9, 0, -1, "d_zero");
        do_op(1'b0, -128, 1, -128, -1, 0, "min_cd");

        // Start pulses at edges 3 and 9 of a running operation are ignored.
        wait_idle(1'b0, "ign");
        @(negedge clk);
        drive(1'b0, 1'b1, 21, 5, 3, 2, 0);
        @(posedge clk);
        #1;
        bus8.start = 1'b0;
        nvalid = 0;
        vedge  = 0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            if (bus8.valid) begin
                nvalid++;
                if (vedge == 0) vedge = k;
            end
            bus8.start = (k == 2 || k == 8);
        end
        check_eq("ign_valid_count", longint'(nvalid), 1);
        check_eq("ign_valid_edge", longint'(vedge), 9);
        check_eq("ign_busy_after", longint'(bus8.busy), 0);
        check_eq("ign_z_hold", get_z(1'b0), 4);

        // Reset at edge 12 of an f-path operation.
        wait_idle(1'b0, "rst_mid");
        @(negedge clk);
        drive(1'b0, 1'b1, 20, 5, -17, 4, 0);
        @(posedge clk);
        #1;
        drive(1'b0, 1'b0, 0, 0, 0, 0, 0);
        repeat (12) @(posedge clk);
        #1;
        rst8 = 1'b1;
        #1;
        check_eq("rst_mid_z", get_z(1'b0), 0);
        check_eq("rst_mid_busy", longint'(bus8.busy), 0);
        check_eq("rst_mid_valid", longint'(bus8.valid), 0);
        check_eq("rst_mid_dz", longint'(bus8.dz), 0);
        nvalid = 0;
        repeat (3) begin
            @(posedge clk);
            #1;
            if (bus8.valid) nvalid++;
        end
        @(negedge clk);
        rst8 = 1'b0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (bus8.valid) nvalid++;
        end
        check_eq("rst_mid_no_valid", longint'(nvalid), 0);
        do_op(1'b0, 9, 2, 0, 0, 0, "after_rst");

        // Random, 8-bit.
        for (int i = 0; i < 150; i++) begin
            a = rand_val(8); b = rand_val(8); c = rand_val(8); d = rand_val(8);
            ref_divmod(8, a, b, q, r);
            zero = ($urandom_range(0, 1) == 1) ? r : rand_val(8);
            do_op(1'b0, a, b, c, d, zero, "rnd8");
        end

        // Random, 64-bit.
        do_op(1'b1, 21, 5, 0, 0, 0, "w64_e");
        do_op(1'b1, 20, 5, -17, 4, 0, "w64_f");
        for (int i = 0; i < 300; i++) begin
            a = rand_val(64); b = rand_val(64); c = rand_val(64); d = rand_val(64);
            ref_divmod(64, a, b, q, r);
            zero = ($urandom_range(0, 1) == 1) ? r : rand_val(64);
            do_op(1'b1, a, b, c, d, zero, "rnd64");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
